// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MD_DIV_STEPS = 32;
    localparam int unsigned MD_CNT_W     = $clog2(MD_DIV_STEPS);

    // Bit indices into ex_hilowen / ex_hiloren
    localparam int unsigned HILO_HI = 1;
    localparam int unsigned HILO_LO = 0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // Context of the operation in flight, used for the DONE write-back
    typedef struct packed {
        logic is_div;
        logic a_neg;
        logic b_neg;
    } md_op_t;

    function automatic logic [XLEN-1:0] neg_if(input logic cond, input logic [XLEN-1:0] v);
        return cond ? ((~v) + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bus of the multiply/divide unit.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic            flush;
    logic            ex_mult;
    logic            ex_div;
    logic            ex_mdsign;
    logic [1:0]      ex_hilowen;
    logic [1:0]      ex_hiloren;
    logic [XLEN-1:0] ex_A;
    logic [XLEN-1:0] ex_B;
    logic            md_stall;
    logic            md_busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] md_rdata;

    modport master (
        output flush, ex_mult, ex_div, ex_mdsign, ex_hilowen, ex_hiloren, ex_A, ex_B,
        input  md_stall, md_busy, hi, lo, md_rdata
    );

    modport slave (
        input  flush, ex_mult, ex_div, ex_mdsign, ex_hilowen, ex_hiloren, ex_A, ex_B,
        output md_stall, md_busy, hi, lo, md_rdata
    );

endinterface

// File: rtl/ex_muldiv_div_radix2.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
module ex_muldiv_div_radix2
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            done_c
);

    logic [2*XLEN-1:0]   rq_q;
    logic [2*XLEN-1:0]   rq_d;
    logic [XLEN-1:0]     dvs_q;
    logic [MD_CNT_W-1:0] cnt_q;
    logic [XLEN:0]       part;
    logic [XLEN-1:0]     diff;
    logic                ge;

    // Shifted partial remainder fits in XLEN+1 bits; the restored result fits in XLEN
    always_comb begin
        part = rq_q[2*XLEN-1:XLEN-1];
        ge   = (part >= {1'b0, dvs_q});
        diff = XLEN'(part - {1'b0, dvs_q});
        if (ge) begin
            rq_d = {diff, rq_q[XLEN-2:0], 1'b1};
        end else begin
            rq_d = {rq_q[2*XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rq_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rq_q  <= {XLEN'(0), dividend};
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rq_q  <= rq_d;
            cnt_q <= cnt_q + MD_CNT_W'(1);
        end
    end

    assign done_c = step && (cnt_q == MD_CNT_W'(MD_DIV_STEPS - 1));
    assign quot   = rq_q[XLEN-1:0];
    assign rem    = rq_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: FSM, multiplier, divide sign fixup, HI/LO and pipeline stall.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    ex_muldiv_if.slave  md
);

    md_state_e         state_q, state_d;
    md_op_t            op_q;
    logic [XLEN:0]     ma_q, mb_q;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              busy_q;

    logic              load_mul, load_div, div_step, write_res, write_mt, md_stall_c;
    logic              div_done_c;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, quot, rem, q_fix, r_fix;

    assign a_neg = md.ex_mdsign & md.ex_A[XLEN-1];
    assign b_neg = md.ex_mdsign & md.ex_B[XLEN-1];
    assign a_mag = neg_if(a_neg, md.ex_A);
    assign b_mag = neg_if(b_neg, md.ex_B);

    // Low 64 bits of the product of the sign-extended operands equal the signed/unsigned product
    assign prod_c = {{(XLEN-1){ma_q[XLEN]}}, ma_q} * {{(XLEN-1){mb_q[XLEN]}}, mb_q};

    assign q_fix = neg_if(op_q.a_neg ^ op_q.b_neg, quot);
    assign r_fix = neg_if(op_q.a_neg, rem);

    ex_muldiv_div_radix2 u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (load_div),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (quot),
        .rem      (rem),
        .done_c   (div_done_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; flush always returns to IDLE and drops the stall
    always_comb begin
        state_d    = state_q;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        div_step   = 1'b0;
        write_res  = 1'b0;
        write_mt   = 1'b0;
        md_stall_c = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (!md.flush) begin
                    if (md.ex_div) begin
                        load_div   = 1'b1;
                        md_stall_c = 1'b1;
                        state_d    = MD_DIV;
                    end else if (md.ex_mult) begin
                        load_mul   = 1'b1;
                        md_stall_c = 1'b1;
                        state_d    = MD_MUL;
                    end else if (md.ex_hilowen != 2'b00) begin
                        write_mt   = 1'b1;
                    end
                end
            end
            MD_MUL: begin
                if (md.flush) begin
                    state_d    = MD_IDLE;
                end else begin
                    md_stall_c = 1'b1;
                    state_d    = MD_DONE;
                end
            end
            MD_DIV: begin
                if (md.flush) begin
                    state_d    = MD_IDLE;
                end else begin
                    md_stall_c = 1'b1;
                    div_step   = 1'b1;
                    if (div_done_c) begin
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                state_d   = MD_IDLE;
                write_res = !md.flush;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Operand capture, product register and HI/LO write-back
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q   <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            prod_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d != MD_IDLE);
            if (load_mul) begin
                ma_q   <= {md.ex_mdsign & md.ex_A[XLEN-1], md.ex_A};
                mb_q   <= {md.ex_mdsign & md.ex_B[XLEN-1], md.ex_B};
                op_q   <= '{is_div: 1'b0, a_neg: 1'b0, b_neg: 1'b0};
            end
            if (load_div) begin
                op_q   <= '{is_div: 1'b1, a_neg: a_neg, b_neg: b_neg};
            end
            if ((state_q == MD_MUL) && !md.flush) begin
                prod_q <= prod_c;
            end
            if (write_res) begin
                if (op_q.is_div) begin
                    hi_q <= r_fix;
                    lo_q <= q_fix;
                end else begin
                    hi_q <= prod_q[2*XLEN-1:XLEN];
                    lo_q <= prod_q[XLEN-1:0];
                end
            end
            if (write_mt) begin
                if (md.ex_hilowen[HILO_HI]) hi_q <= md.ex_A;
                if (md.ex_hilowen[HILO_LO]) lo_q <= md.ex_A;
            end
        end
    end

    assign md.md_stall = md_stall_c;
    assign md.md_busy  = busy_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.md_rdata = md.ex_hiloren[HILO_HI] ? hi_q :
                         (md.ex_hiloren[HILO_LO] ? lo_q : '0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: multiply/divide results, stall length, MTxx/MFxx, flush and reset.
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic resetn;
    int   passed = 0;
    int   total  = 0;
    int   n;

    always #5 clk = ~clk;

    ex_muldiv_if mdi ();

    ex_muldiv dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (mdi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m, input logic d, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
        mdi.ex_mult   = m;
        mdi.ex_div    = d;
        mdi.ex_mdsign = s;
        mdi.ex_A      = a;
        mdi.ex_B      = b;
        #1;
    endtask

    // Counts stalled cycles, then lets the instruction leave EX on the DONE edge
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (mdi.md_stall === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        tick();
        mdi.ex_mult    = 1'b0;
        mdi.ex_div     = 1'b0;
        mdi.ex_hilowen = 2'b00;
        #1;
    endtask

    initial begin
        resetn         = 1'b0;
        mdi.flush      = 1'b0;
        mdi.ex_mult    = 1'b0;
        mdi.ex_div     = 1'b0;
        mdi.ex_mdsign  = 1'b0;
        mdi.ex_hilowen = 2'b00;
        mdi.ex_hiloren = 2'b00;
        mdi.ex_A       = '0;
        mdi.ex_B       = '0;
        tick();
        tick();
        check("rst_hi", mdi.hi, 32'h0);
        check("rst_lo", mdi.lo, 32'h0);
        check("rst_busy", 32'(mdi.md_busy), 32'd0);
        resetn = 1'b1;
        tick();

        // Signed MULT -2 * 3
        start_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3);
        check("mult_stall_start", 32'(mdi.md_stall), 32'd1);
        wait_done(n);
        check("mult_stall_cycles", 32'(n), 32'd2);
        check("mult_hi", mdi.hi, 32'hFFFF_FFFF);
        check("mult_lo", mdi.lo, 32'hFFFF_FFFA);

        // DIVU 100 / 7
        start_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(n);
        check("divu_stall_cycles", 32'(n), 32'd33);
        check("divu_lo", mdi.lo, 32'd14);
        check("divu_hi", mdi.hi, 32'd2);

        // DIV -7 / 2
        start_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        check("div_neg_lo", mdi.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", mdi.hi, 32'hFFFF_FFFF);

        // DIVU 5 / 0
        start_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        wait_done(n);
        check("div0_lo", mdi.lo, 32'hFFFF_FFFF);
        check("div0_hi", mdi.hi, 32'd5);

        // Preload HI/LO through MTHI/MTLO and read back
        mdi.ex_hilowen = 2'b10;
        mdi.ex_A       = 32'h1111_1111;
        #1;
        check("mthi_no_stall", 32'(mdi.md_stall), 32'd0);
        tick();
        mdi.ex_hilowen = 2'b01;
        mdi.ex_A       = 32'h2222_2222;
        tick();
        mdi.ex_hilowen = 2'b00;
        mdi.ex_hiloren = 2'b10;
        #1;
        check("mfhi_pre", mdi.md_rdata, 32'h1111_1111);
        mdi.ex_hiloren = 2'b01;
        #1;
        check("mflo_pre", mdi.md_rdata, 32'h2222_2222);
        mdi.ex_hiloren = 2'b00;
        #1;
        check("mfnone", mdi.md_rdata, 32'h0);

        // Flush at iteration 10 of a signed DIV
        start_op(1'b0, 1'b1, 1'b1, 32'd1000, 32'd3);
        tick();
        repeat (9) tick();
        check("flush_busy_before", 32'(mdi.md_busy), 32'd1);
        check("flush_stall_before", 32'(mdi.md_stall), 32'd1);
        mdi.flush = 1'b1;
        #1;
        check("flush_stall_drop", 32'(mdi.md_stall), 32'd0);
        tick();
        mdi.flush  = 1'b0;
        mdi.ex_div = 1'b0;
        #1;
        check("flush_busy_after", 32'(mdi.md_busy), 32'd0);
        check("flush_hi_kept", mdi.hi, 32'h1111_1111);
        check("flush_lo_kept", mdi.lo, 32'h2222_2222);

        // Flush together with a new start in IDLE: nothing starts
        mdi.flush = 1'b1;
        start_op(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
        check("flush_start_stall", 32'(mdi.md_stall), 32'd0);
        tick();
        mdi.flush   = 1'b0;
        mdi.ex_mult = 1'b0;
        #1;
        check("flush_start_busy", 32'(mdi.md_busy), 32'd0);
        check("flush_start_lo", mdi.lo, 32'h2222_2222);

        // MTHI then MFHI next cycle
        mdi.ex_hilowen = 2'b10;
        mdi.ex_A       = 32'hDEAD_BEEF;
        #1;
        check("mthi2_no_stall", 32'(mdi.md_stall), 32'd0);
        tick();
        mdi.ex_hilowen = 2'b00;
        mdi.ex_hiloren = 2'b10;
        #1;
        check("mfhi_deadbeef", mdi.md_rdata, 32'hDEAD_BEEF);
        mdi.ex_hiloren = 2'b00;

        // MTLO alongside a DIVU start is ignored
        mdi.ex_hilowen = 2'b01;
        start_op(1'b0, 1'b1, 1'b0, 32'd40, 32'd5);
        tick();
        check("mtlo_ignored", mdi.lo, 32'h2222_2222);
        check("mtlo_div_busy", 32'(mdi.md_busy), 32'd1);
        wait_done(n);
        check("mtlo_div_cycles", 32'(n), 32'd32);
        check("mtlo_div_lo", mdi.lo, 32'd8);
        check("mtlo_div_hi", mdi.hi, 32'd0);

        // MULTU max * max, then DIVU 9 / 3 with no bubble
        start_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        check("multu_hi", mdi.hi, 32'hFFFF_FFFE);
        check("multu_lo", mdi.lo, 32'h0000_0001);
        start_op(1'b0, 1'b1, 1'b0, 32'd9, 32'd3);
        check("b2b_stall_now", 32'(mdi.md_stall), 32'd1);
        wait_done(n);
        check("b2b_div_cycles", 32'(n), 32'd33);
        check("b2b_div_hi", mdi.hi, 32'd0);
        check("b2b_div_lo", mdi.lo, 32'd3);

        // Reset in the middle of a DIV
        start_op(1'b0, 1'b1, 1'b0, 32'd50, 32'd7);
        repeat (5) tick();
        check("rst_mid_busy_before", 32'(mdi.md_busy), 32'd1);
        resetn     = 1'b0;
        mdi.ex_div = 1'b0;
        tick();
        check("rst_mid_hi", mdi.hi, 32'h0);
        check("rst_mid_lo", mdi.lo, 32'h0);
        check("rst_mid_busy", 32'(mdi.md_busy), 32'd0);
        check("rst_mid_stall", 32'(mdi.md_stall), 32'd0);
        resetn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
